// File: rtl/hiscore_port_pkg.sv
// Shared types and helpers for the game-side hiscore RAM port.
// The FSM state type and the RAM window decode live here.
package hiscore_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT,
        ACK
    } hs_state_e;

    // Unsigned 16-bit offset from the window base.
    // Addresses below the base wrap to large offsets, so they never alias into the window.
    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input int          aw);
        logic [31:0] offset;
        offset = {16'd0, addr - base};
        return (offset >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/hiscore_ram_port_if.sv
// Hiscore engine RAM access bus: a level request with a 4-phase handshake.
// The master is the hiscore engine and the slave is the game-side RAM port.
interface hiscore_ram_port_if;

    logic        hs_req;
    logic        hs_write;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic        hs_ack;
    logic        hs_err;

    modport master (
        output hs_req, hs_write, hs_address, hs_data_in,
        input  hs_data_out, hs_ack, hs_err
    );

    modport slave (
        input  hs_req, hs_write, hs_address, hs_data_in,
        output hs_data_out, hs_ack, hs_err
    );

endinterface

// File: rtl/hiscore_port_ram.sv
// Single-port work RAM for the game CPU, organised as 2^AW x 8.
// Reads are registered, and a read in the same cycle as a write returns the old data.
module hiscore_port_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_reg [0:(1 << AW) - 1];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        rdata_reg <= mem_reg[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/hiscore_ram_port.sv
// Game-side responder for the hiscore RAM bus. It arbitrates the CPU work RAM
// between the game CPU and hiscore accesses, which are granted while the CPU is paused or idle.
module hiscore_ram_port
    import hiscore_port_pkg::*;
#(
    parameter logic [15:0] RAM_BASE = 16'h4000,
    parameter int          RAM_AW   = 11,
    parameter logic [7:0]  OOR_DATA = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              paused,
    input  logic              cpu_mreq,
    input  logic              cpu_wr,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait,
    hiscore_ram_port_if.slave hs
);

    hs_state_e         state_reg, state_next;
    logic [RAM_AW-1:0] hs_off_reg;
    logic              hs_wr_reg;
    logic              hs_inwin_reg;
    logic [7:0]        hs_wdata_reg;
    logic [7:0]        hs_data_out_reg;
    logic              hs_err_reg;
    logic [7:0]        cpu_dout_hold_reg;
    logic              cpu_rd_pend_reg;

    logic              grant;
    logic              hs_owns;
    logic [RAM_AW-1:0] hs_off;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    assign grant   = hs.hs_req && (paused || !cpu_mreq);
    assign hs_owns = (state_reg == ACCESS) || (state_reg == RDWAIT);
    assign hs_off  = RAM_AW'(hs.hs_address - RAM_BASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  state_next = (hs_inwin_reg && !hs_wr_reg) ? RDWAIT : ACK;
            RDWAIT:  state_next = ACK;
            ACK:     if (!hs.hs_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_off_reg        <= '0;
            hs_wr_reg         <= 1'b0;
            hs_inwin_reg      <= 1'b0;
            hs_wdata_reg      <= 8'd0;
            hs_data_out_reg   <= 8'd0;
            hs_err_reg        <= 1'b0;
            cpu_dout_hold_reg <= 8'd0;
            cpu_rd_pend_reg   <= 1'b0;
        end else begin
            // The RAM output belongs to the CPU only when the read was issued while the CPU owned the RAM.
            cpu_rd_pend_reg <= cpu_mreq && !cpu_wr && !hs_owns;
            if (cpu_rd_pend_reg) begin
                cpu_dout_hold_reg <= ram_rdata;
            end

            if (state_reg == IDLE && grant) begin
                hs_off_reg   <= hs_off;
                hs_wr_reg    <= hs.hs_write;
                hs_wdata_reg <= hs.hs_data_in;
                hs_inwin_reg <= in_window(hs.hs_address, RAM_BASE, RAM_AW);
                hs_err_reg   <= 1'b0;
            end

            if (state_reg == ACCESS && !hs_inwin_reg) begin
                hs_data_out_reg <= OOR_DATA;
                hs_err_reg      <= 1'b1;
            end

            if (state_reg == RDWAIT) begin
                hs_data_out_reg <= ram_rdata;
            end
        end
    end

    // Reset takes priority over any write that lands in the same cycle.
    assign ram_addr  = hs_owns ? hs_off_reg   : cpu_addr;
    assign ram_wdata = hs_owns ? hs_wdata_reg : cpu_din;
    assign ram_we    = !reset && (hs_owns ? (state_reg == ACCESS && hs_inwin_reg && hs_wr_reg)
                                          : (cpu_mreq && cpu_wr));

    hiscore_port_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign cpu_wait       = cpu_mreq && hs_owns;
    assign cpu_dout       = cpu_rd_pend_reg ? ram_rdata : cpu_dout_hold_reg;
    assign hs.hs_ack      = (state_reg == ACK);
    assign hs.hs_err      = hs_err_reg;
    assign hs.hs_data_out = hs_data_out_reg;

endmodule

// File: tb/tb_hiscore_ram_port.sv
// Self-checking bench for hiscore_ram_port. It runs directed arbitration cases and random
// hiscore traffic against a flat byte-array model of the work RAM.
module tb_hiscore_ram_port;

    localparam logic [15:0] BASE  = 16'h4000;
    localparam int          AW    = 11;
    localparam int          DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          paused;
    logic          cpu_mreq;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_wait;

    hiscore_ram_port_if hs_bus();

    hiscore_ram_port #(
        .RAM_BASE (BASE),
        .RAM_AW   (AW),
        .OOR_DATA (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .paused   (paused),
        .cpu_mreq (cpu_mreq),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_wait (cpu_wait),
        .hs       (hs_bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] ref_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_offset(input logic [15:0] addr);
        return int'(addr) - int'(BASE);
    endfunction

    function automatic bit ref_in_window(input logic [15:0] addr);
        int off;
        off = ref_offset(addr);
        return (off >= 0) && (off < DEPTH);
    endfunction

    task automatic cpu_write(input int addr, input logic [7:0] data);
        cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = AW'(addr); cpu_din = data;
        tick();
        ref_mem[addr] = data;
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input int addr);
        cpu_mreq = 1'b1; cpu_wr = 1'b0; cpu_addr = AW'(addr);
        tick();
        check(tag, {24'd0, cpu_dout}, {24'd0, ref_mem[addr]});
        $display("cpu rd off=%03h data=%02h", addr, cpu_dout);
        cpu_mreq = 1'b0;
    endtask

    // Full 4-phase hiscore transaction; the grant must be available when it starts.
    task automatic hs_txn(input logic [15:0] addr, input logic wr, input logic [7:0] data);
        int cycles;
        bit inw;
        int exp_lat;
        cycles  = 0;
        inw     = ref_in_window(addr);
        exp_lat = (inw && !wr) ? 3 : 2;
        hs_bus.hs_address = addr; hs_bus.hs_write = wr; hs_bus.hs_data_in = data;
        hs_bus.hs_req = 1'b1;
        while (!hs_bus.hs_ack && cycles < 20) begin
            tick();
            cycles++;
        end
        if (!hs_bus.hs_ack) begin
            check("ack_timeout", 32'd0, 32'd1);
            hs_bus.hs_req = 1'b0;
            tick();
            return;
        end
        check("ack_latency", cycles, exp_lat);
        check("hs_err", {31'd0, hs_bus.hs_err}, {31'd0, !inw});
        if (!inw) check("oor_data", {24'd0, hs_bus.hs_data_out}, 32'hFF);
        else if (!wr) check("rd_data", {24'd0, hs_bus.hs_data_out}, {24'd0, ref_mem[ref_offset(addr)]});
        else ref_mem[ref_offset(addr)] = data;
        $display("hs %s addr=%04h data=%02h lat=%0d err=%0d", wr ? "wr" : "rd", addr,
                 wr ? data : hs_bus.hs_data_out, cycles, hs_bus.hs_err);
        hs_bus.hs_req = 1'b0;
        tick();
        check("ack_release", {31'd0, hs_bus.hs_ack}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra;
        int          cyc;

        reset = 1'b1; paused = 1'b0; cpu_mreq = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = 8'd0;
        hs_bus.hs_req = 1'b0; hs_bus.hs_write = 1'b0; hs_bus.hs_address = 16'd0; hs_bus.hs_data_in = 8'd0;
        tick(); tick();
        check("rst_ack", {31'd0, hs_bus.hs_ack}, 32'd0);
        check("rst_err", {31'd0, hs_bus.hs_err}, 32'd0);
        check("rst_hs_dout", {24'd0, hs_bus.hs_data_out}, 32'd0);
        check("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
        check("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = AW'(i); cpu_din = 8'($urandom);
            ref_mem[i] = cpu_din;
            tick();
        end
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
        cpu_write(16'h010, 8'h5A);

        // Paused read of a preloaded byte.
        paused = 1'b1;
        hs_txn(16'h4010, 1'b0, 8'h00);
        check("paused_rd_5a", {24'd0, hs_bus.hs_data_out}, 32'h5A);

        // Write the top byte of the window, then read it back from the CPU side.
        hs_txn(16'h47FF, 1'b1, 8'hC3);
        paused = 1'b0;
        cpu_mreq = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h7FF;
        tick();
        check("cpu_readback_c3", {24'd0, cpu_dout}, 32'hC3);
        cpu_mreq = 1'b0;

        // Addresses just outside both ends of the window.
        paused = 1'b1;
        hs_txn(16'h4800, 1'b1, 8'h99);
        hs_txn(16'h3FFF, 1'b1, 8'h99);
        hs_txn(16'h4800, 1'b0, 8'h00);
        hs_txn(16'h3FFF, 1'b0, 8'h00);
        cpu_read("oor_no_alias_lo", 16'h000);
        cpu_read("oor_no_alias_hi", 16'h7FF);

        // Contention: the CPU holds the RAM until it goes idle for one cycle.
        paused = 1'b0;
        cpu_write(16'h123, 8'hEE);
        cpu_write(16'h055, 8'h6B);
        hs_bus.hs_address = 16'h4123; hs_bus.hs_write = 1'b0; hs_bus.hs_req = 1'b1;
        cpu_mreq = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h055;
        repeat (10) tick();
        check("contend_no_ack", {31'd0, hs_bus.hs_ack}, 32'd0);
        check("contend_no_wait", {31'd0, cpu_wait}, 32'd0);
        cpu_mreq = 1'b0;
        tick();
        cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_din = 8'h11; cpu_addr = 11'h123;
        #1;
        check("contend_wait", {31'd0, cpu_wait}, 32'd1);
        check("contend_dout_hold", {24'd0, cpu_dout}, 32'h6B);
        tick();
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
        tick();
        check("contend_ack", {31'd0, hs_bus.hs_ack}, 32'd1);
        check("contend_rd", {24'd0, hs_bus.hs_data_out}, 32'hEE);
        $display("hs rd addr=4123 data=%02h under contention", hs_bus.hs_data_out);
        hs_bus.hs_req = 1'b0;
        tick();
        cpu_read("contend_wr_dropped", 16'h123);

        // Holding the request after ack must not start a second access.
        paused = 1'b1;
        cpu_write(16'h200, 8'h00);
        cpu_write(16'h201, 8'h00);
        hs_bus.hs_address = 16'h4200; hs_bus.hs_write = 1'b1; hs_bus.hs_data_in = 8'h77;
        hs_bus.hs_req = 1'b1;
        cyc = 0;
        while (!hs_bus.hs_ack && cyc < 20) begin
            tick();
            cyc++;
        end
        check("hold_first_ack", {31'd0, hs_bus.hs_ack}, 32'd1);
        ref_mem[16'h200] = 8'h77;
        for (int i = 0; i < 10; i++) begin
            hs_bus.hs_address = 16'h4201; hs_bus.hs_data_in = 8'($urandom_range(255, 1));
            tick();
            check("hold_ack", {31'd0, hs_bus.hs_ack}, 32'd1);
        end
        hs_bus.hs_req = 1'b0;
        tick();
        check("hold_release", {31'd0, hs_bus.hs_ack}, 32'd0);
        cpu_read("hold_target", 16'h200);
        cpu_read("hold_no_second", 16'h201);

        // Reset landing on the ACCESS cycle of a write.
        hs_txn(16'h4800, 1'b0, 8'h00);
        cpu_write(16'h300, 8'h3C);
        cpu_read("pre_rst_rd", 16'h055);
        hs_bus.hs_address = 16'h4300; hs_bus.hs_write = 1'b1; hs_bus.hs_data_in = 8'hA5;
        hs_bus.hs_req = 1'b1;
        tick();
        reset = 1'b1;
        cpu_mreq = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h055;
        tick();
        reset = 1'b0; hs_bus.hs_req = 1'b0;
        check("midrst_ack", {31'd0, hs_bus.hs_ack}, 32'd0);
        check("midrst_err", {31'd0, hs_bus.hs_err}, 32'd0);
        check("midrst_hs_dout", {24'd0, hs_bus.hs_data_out}, 32'd0);
        check("midrst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
        check("midrst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
        cpu_mreq = 1'b0;
        tick();
        cpu_read("midrst_unchanged", 16'h300);

        // Random hiscore and CPU traffic around and inside the window.
        for (int t = 0; t < 40; t++) begin
            paused = 1'($urandom);
            ra = 16'($urandom_range(16'h4900, 16'h3F00));
            hs_txn(ra, 1'($urandom), 8'($urandom));
            if ($urandom_range(3, 0) == 0) cpu_write(int'($urandom_range(DEPTH - 1, 0)), 8'($urandom));
        end
        for (int t = 0; t < 8; t++) begin
            cpu_read("rand_cpu_rd", int'($urandom_range(DEPTH - 1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hiscore_ram_port.md
Name: hiscore_ram_port

Overview:
- Game-side responder for the hiscore engine's RAM access bus.
- Owns the game's CPU work RAM (single-port, synchronous read) and arbitrates it between the game CPU and hiscore read/write requests.
- Hiscore accesses are granted when the CPU is paused or idle. A CPU access that collides with an owned hiscore cycle is stalled via cpu_wait.
- Sits between naughty_boy and hiscore in emu on clk_sys.

Parameters:
- RAM_BASE, 16'h4000, CPU/hiscore address of work RAM byte 0.
- RAM_AW, 11, work RAM address width (2^RAM_AW bytes).
- OOR_DATA, 8'hFF, read data returned for out-of-window hiscore addresses.

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- paused  in  1  CPU halted by the pause system; hiscore may own RAM freely.
- cpu_mreq  in  1  CPU RAM access this cycle (address already decoded to window).
- cpu_wr  in  1  CPU write strobe, qualified by cpu_mreq.
- cpu_addr  in  RAM_AW  CPU RAM offset.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  RAM read data to CPU, 1-cycle latency.
- cpu_wait  out  1  stall CPU; RAM owned by hiscore.
- hs_req  in  1  hiscore request, level, 4-phase.
- hs_write  in  1  1 = write, 0 = read; sampled with hs_req.
- hs_address  in  16  hiscore absolute address.
- hs_data_in  in  8  hiscore write data.
- hs_data_out  out  8  hiscore read data; valid while hs_ack is high.
- hs_ack  out  1  request done; held until hs_req falls.
- hs_err  out  1  request address was outside the window; valid with hs_ack.

Behaviour:
- Reset (synchronous, active-high) values:
  - state IDLE.
  - hs_ack = 0, hs_err = 0, hs_data_out = 0, cpu_wait = 0, cpu_dout = 0.
  - RAM contents are not cleared.
- States and transitions:
  - IDLE: if hs_req && (paused || !cpu_mreq), latch address, write flag and data, then go to ACCESS. Otherwise the CPU owns the RAM.
  - ACCESS:
    - Hiscore owns RAM.
    - In-window write: RAM write, then go to ACK.
    - In-window read: go to RDWAIT.
    - Out-of-window: no RAM access, hs_data_out = OOR_DATA, hs_err = 1, go to ACK.
  - RDWAIT: capture RAM output into hs_data_out, go to ACK.
  - ACK: hs_ack = 1; remain until hs_req = 0, then go to IDLE with hs_ack = 0 on the next cycle.
- Latency from hs_req rise to hs_ack, with grant available: write 2 cycles, read 3 cycles, out-of-window 2 cycles.
- Window decode: in-window iff hs_address - RAM_BASE < 2^RAM_AW. Use a 16-bit unsigned subtract; no wrap-around aliasing.
- Ownership is latched at the IDLE->ACCESS transition. If paused falls mid-transaction, the transaction still completes.
- cpu_wait = cpu_mreq && state in {ACCESS, RDWAIT}. While hiscore owns RAM, the CPU write is dropped and cpu_dout holds its last value. The CPU re-issues the access after cpu_wait drops.
- In ACK and IDLE the CPU owns RAM, so a CPU write and an ACK hold in the same cycle do not conflict.
- Simultaneous hs_req rise and cpu_mreq with paused = 0: the CPU wins and the request waits in IDLE indefinitely. There is no timeout; the pause system guarantees progress.
- hs_write, hs_address and hs_data_in are ignored after latching; changes during ACCESS have no effect.
- Reset mid-transaction: return to IDLE. A write in ACCESS in that same cycle is suppressed, because reset has priority.

Decomposition:
- Package hiscore_port_pkg holds:
  - state enum {IDLE, ACCESS, RDWAIT, ACK};
  - an in_window function.
- One sub-module, hiscore_port_ram: single-port synchronous RAM, 2^RAM_AW x 8, registered read, write-first not required.

Test Plan:
- Paused read: preload byte 0x5A at offset 0x010; paused = 1, hs_req with hs_address = 0x4010, hs_write = 0 -> hs_ack on cycle 3, hs_data_out = 0x5A, hs_err = 0.
- Write then CPU readback: paused = 1, hs write 0xC3 to 0x47FF; drop req; release pause; CPU read offset 0x7FF -> cpu_dout = 0xC3 one cycle later.
- Out-of-window: hs_address = 0x4800 and then 0x3FFF -> hs_ack after 2 cycles, hs_data_out = 0xFF, hs_err = 1, RAM unchanged.
- Contention:
  - Setup: paused = 0, cpu_mreq continuous -> no hs_ack.
  - cpu_mreq drops for 1 cycle -> grant. CPU resumes in ACCESS -> cpu_wait = 1 for that cycle, the CPU write of 0x11 is dropped, and the hiscore read completes.
- 4-phase hold: keep hs_req high 10 cycles after ack -> hs_ack stays high, no second access. Deassert -> hs_ack low the next cycle.
- Reset mid-write: assert reset during ACCESS of a write -> target byte unchanged, all outputs return to reset values the next cycle.
